dff_bank_checked: RTL and testbench

DFF_BANK_CHECKED -- requirements
Module: dff_bank_checked

---
 rtl/dff_bank_pkg.sv | 12 +
 rtl/dff_bank_checked_rec_timer.sv | 36 +++
 rtl/dff_bank_checked.sv | 134 +++++++++++++
 tb/tb_dff_bank_checked.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/dff_bank_pkg.sv
// Shared types for the checked D flip-flop bank: FSM state encoding and recovery counter width.
package dff_bank_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FORCED  = 2'd1,
    RECOVER = 2'd2
  } state_t;

endpackage

// File: rtl/dff_bank_checked_rec_timer.sv
// Recovery down-counter: loads the recovery length, decrements while enabled, flags the last cycle.
module rec_timer
  import dff_bank_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The FSM leaves recovery on the cycle the count sits at 1.
  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/dff_bank_checked.sv
// Register bank with synchronous preset/clear, recovery window and timing-violation tracking.
// Define DFF_BANK_CHECKED_VCNT_EN to add the saturating viol_cnt output.
module dff_bank_checked
  import dff_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               REC_CYC   = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             preset_n,
  input  logic             clear_n,
  input  logic             notifier,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             q_valid,
  output logic             viol_sticky,
  output logic             rec_err,
`ifdef DFF_BANK_CHECKED_VCNT_EN
  output logic [7:0]       viol_cnt,
`endif
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] REC_LD = CNT_W'(REC_CYC);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic             valid_q, valid_d;
  logic             sticky_q, sticky_d;
  logic             rec_err_q, rec_err_d;
  logic             tmr_load, tmr_dec, tmr_done;
  logic             force_act;

  assign force_act = !preset_n || !clear_n;

  rec_timer u_rec_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (REC_LD),
    .done     (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    reg_d     = reg_q;
    valid_d   = valid_q;
    sticky_d  = sticky_q | notifier;
    rec_err_d = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    if (force_act) begin
      // A force always writes q, even alongside a violation; clear dominates preset.
      state_d = FORCED;
      reg_d   = !clear_n ? '0 : '1;
      valid_d = !notifier;
    end else begin
      case (state_q)
        RUN: begin
          if (notifier) begin
            valid_d = 1'b0;
          end else if (load) begin
            reg_d   = data;
            valid_d = 1'b1;
          end
        end
        FORCED: begin
          if (REC_CYC == 0) begin
            state_d = RUN;
          end else begin
            state_d  = RECOVER;
            tmr_load = 1'b1;
          end
          if (notifier) valid_d = 1'b0;
        end
        RECOVER: begin
          tmr_dec   = 1'b1;
          rec_err_d = load;
          if (tmr_done) state_d = RUN;
          if (notifier) valid_d = 1'b0;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      reg_q     <= RESET_VAL;
      valid_q   <= 1'b1;
      sticky_q  <= 1'b0;
      rec_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      reg_q     <= reg_d;
      valid_q   <= valid_d;
      sticky_q  <= sticky_d;
      rec_err_q <= rec_err_d;
    end
  end

`ifdef DFF_BANK_CHECKED_VCNT_EN
  logic [7:0] vcnt_q, vcnt_d;

  always_comb begin
    vcnt_d = vcnt_q;
    if (notifier && (vcnt_q != 8'hFF)) vcnt_d = vcnt_q + 8'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vcnt_q <= 8'd0;
    end else begin
      vcnt_q <= vcnt_d;
    end
  end

  assign viol_cnt = vcnt_q;
`endif

  assign q           = reg_q;
  assign qbar        = ~reg_q;
  assign q_valid     = valid_q;
  assign viol_sticky = sticky_q;
  assign rec_err     = rec_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_dff_bank_checked.sv
// Bench for dff_bank_checked: directed vectors with a per-cycle expected-output queue.
module tb_dff_bank_checked;

  logic       clock = 1'b0;
  logic       reset, load, preset_n, clear_n, notifier;
  logic [7:0] data;
  logic [7:0] q, qbar;
  logic       q_valid, viol_sticky, rec_err;
  logic [1:0] dbg_state;

  logic       r0_reset, r0_load, r0_preset_n, r0_clear_n, r0_notifier;
  logic [7:0] r0_data;
  logic [7:0] r0_q, r0_qbar;
  logic       r0_q_valid, r0_viol_sticky, r0_rec_err;
  logic [1:0] r0_dbg_state;

`ifdef DFF_BANK_CHECKED_VCNT_EN
  logic [7:0] viol_cnt, r0_viol_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [18:0] exp_q[$];
  string       name_q[$];
  logic [18:0] r0_exp_q[$];
  string       r0_name_q[$];

  logic [18:0] mon_exp, mon_act;
  string       mon_name;

  always #5 clock = ~clock;

  dff_bank_checked #(.WIDTH(8), .REC_CYC(2), .RESET_VAL(8'h00)) dut (
    .clock(clock), .reset(reset), .data(data), .load(load),
    .preset_n(preset_n), .clear_n(clear_n), .notifier(notifier),
    .q(q), .qbar(qbar), .q_valid(q_valid), .viol_sticky(viol_sticky),
    .rec_err(rec_err),
`ifdef DFF_BANK_CHECKED_VCNT_EN
    .viol_cnt(viol_cnt),
`endif
    .dbg_state(dbg_state)
  );

  dff_bank_checked #(.WIDTH(8), .REC_CYC(0), .RESET_VAL(8'h00)) dut_r0 (
    .clock(clock), .reset(r0_reset), .data(r0_data), .load(r0_load),
    .preset_n(r0_preset_n), .clear_n(r0_clear_n), .notifier(r0_notifier),
    .q(r0_q), .qbar(r0_qbar), .q_valid(r0_q_valid), .viol_sticky(r0_viol_sticky),
    .rec_err(r0_rec_err),
`ifdef DFF_BANK_CHECKED_VCNT_EN
    .viol_cnt(r0_viol_cnt),
`endif
    .dbg_state(r0_dbg_state)
  );

  // Inputs change on the negedge; the expected outputs after the next posedge are queued.
  task automatic step(input logic rst, input logic ld, input logic pn, input logic cn,
                      input logic nt, input logic [7:0] d, input logic [7:0] eq,
                      input logic ev, input logic es, input logic ee, input string nm);
    @(negedge clock);
    reset = rst; load = ld; preset_n = pn; clear_n = cn; notifier = nt; data = d;
    exp_q.push_back({eq, ~eq, ev, es, ee});
    name_q.push_back(nm);
  endtask

  task automatic step0(input logic rst, input logic ld, input logic cn,
                       input logic [7:0] d, input logic [7:0] eq,
                       input logic ev, input logic ee, input string nm);
    @(negedge clock);
    r0_reset = rst; r0_load = ld; r0_clear_n = cn; r0_data = d;
    r0_exp_q.push_back({eq, ~eq, ev, 1'b0, ee});
    r0_name_q.push_back(nm);
  endtask

  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_act  = {q, qbar, q_valid, viol_sticky, rec_err};
      vectors++;
      if (mon_act !== mon_exp) begin
        miscompares++;
        $display("FAIL %s: got {q,qbar,v,s,e}=%h required %h", mon_name, mon_act, mon_exp);
      end
    end
    if (r0_exp_q.size() > 0) begin
      mon_exp  = r0_exp_q.pop_front();
      mon_name = r0_name_q.pop_front();
      mon_act  = {r0_q, r0_qbar, r0_q_valid, r0_viol_sticky, r0_rec_err};
      vectors++;
      if (mon_act !== mon_exp) begin
        miscompares++;
        $display("FAIL %s: got {q,qbar,v,s,e}=%h required %h", mon_name, mon_act, mon_exp);
      end
    end
  end

  initial begin
    reset = 1'b1; load = 1'b0; preset_n = 1'b1; clear_n = 1'b1; notifier = 1'b0; data = 8'h00;
    r0_reset = 1'b1; r0_load = 1'b0; r0_preset_n = 1'b1; r0_clear_n = 1'b1;
    r0_notifier = 1'b0; r0_data = 8'h00;

    //   rst ld pn cn nt data   q     v  s  e
    step(1, 0, 1, 1, 0, 8'h00, 8'h00, 1, 0, 0, "reset");
    step(0, 1, 1, 1, 0, 8'hA5, 8'hA5, 1, 0, 0, "load_a5");
    step(0, 0, 1, 1, 0, 8'h00, 8'hA5, 1, 0, 0, "hold_a5");
    step(0, 0, 1, 0, 0, 8'h00, 8'h00, 1, 0, 0, "clear");
    step(0, 0, 1, 1, 0, 8'h00, 8'h00, 1, 0, 0, "release");
    step(0, 1, 1, 1, 0, 8'h77, 8'h00, 1, 0, 1, "rec_reject1");
    step(0, 1, 1, 1, 0, 8'h77, 8'h00, 1, 0, 1, "rec_reject2");
    step(0, 1, 1, 1, 0, 8'h3C, 8'h3C, 1, 0, 0, "load_3c");
    step(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, "both_low");
    step(0, 0, 0, 1, 0, 8'h00, 8'hFF, 1, 0, 0, "preset");
    step(0, 0, 1, 1, 0, 8'h00, 8'hFF, 1, 0, 0, "release2");
    step(0, 0, 1, 1, 0, 8'h00, 8'hFF, 1, 0, 0, "recover_a");
    step(0, 0, 1, 1, 0, 8'h00, 8'hFF, 1, 0, 0, "recover_b");
    step(0, 1, 1, 1, 0, 8'h12, 8'h12, 1, 0, 0, "load_12");
    step(0, 1, 1, 1, 1, 8'hFF, 8'h12, 0, 1, 0, "notif_load");
    step(0, 1, 1, 1, 0, 8'h34, 8'h34, 1, 1, 0, "load_34");
    step(0, 0, 0, 1, 1, 8'h00, 8'hFF, 0, 1, 0, "force_notif");
    step(0, 0, 0, 1, 0, 8'h00, 8'hFF, 1, 1, 0, "force_again");
    step(0, 0, 1, 1, 0, 8'h00, 8'hFF, 1, 1, 0, "release3");
    step(1, 1, 1, 1, 0, 8'h66, 8'h00, 1, 0, 0, "reset_mid_rec");
    step(0, 1, 1, 1, 0, 8'h5A, 8'h5A, 1, 0, 0, "after_reset");
    step(0, 0, 1, 1, 0, 8'h00, 8'h5A, 1, 0, 0, "hold_5a");

    //    rst ld cn data   q     v  e
    step0(1, 0, 1, 8'h00, 8'h00, 1, 0, "r0_reset");
    step0(0, 0, 0, 8'h00, 8'h00, 1, 0, "r0_clear");
    step0(0, 0, 1, 8'h00, 8'h00, 1, 0, "r0_release");
    step0(0, 1, 1, 8'h99, 8'h99, 1, 0, "r0_load_99");
    step0(0, 0, 1, 8'h00, 8'h99, 1, 0, "r0_no_err");

`ifdef DFF_BANK_CHECKED_VCNT_EN
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      load = 1'b0; notifier = 1'b1;
    end
    @(negedge clock);
    notifier = 1'b0;
    @(negedge clock);
    vectors++;
    if (viol_cnt !== 8'hFF) begin
      miscompares++;
      $display("FAIL viol_cnt_sat: got %0d required 255", viol_cnt);
    end
`endif

    for (int i = 0; i < 20 && (exp_q.size() > 0 || r0_exp_q.size() > 0); i++) @(posedge clock);
    @(negedge clock);
    if (exp_q.size() > 0 || r0_exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size() + r0_exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
